// File: rtl/rx_buffer.sv
// rx_buffer: receive-side beat buffer between the aligner and the DMA write path.
//
// Captures 64-byte aligned beats {data, byte count, eop} into a DEPTH-entry store.
// The store is a circular RAM plus one output register, and it is presented on a
// valid/ready handshake. It also gives the read-request engine a credit signal:
// each 128-byte request reserves two entries, so the aligner (which cannot be
// stalled) never finds the buffer full.
//
// Ports
//   clk           clock
//   reset         asynchronous active-low reset
//   align_val_i   aligned beat strobe (no backpressure)
//   align_dat_i   aligned beat data, 64 bytes
//   align_byte_i  valid bytes in beat, 1..64
//   align_eop_i   last beat of transfer
//   req_issue_i   read engine issued one 128-byte request (reserves 2 entries)
//   credit_ok_o   at least 2 free, unreserved entries
//   buf_val_o     output beat valid
//   buf_rdy_i     consumer accepts beat
//   buf_dat_o     output beat data
//   buf_byte_o    output beat byte count
//   buf_eop_o     output beat end-of-packet
//   pkt_done_o    one-cycle pulse after an eop beat is accepted
//   buf_cnt_o     occupancy, 0..DEPTH (RAM + output register)
//   err_o         sticky: [0] write while full, [1] request without credit
module rx_buffer #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          align_val_i,
  input  logic [511:0]  align_dat_i,
  input  logic [6:0]    align_byte_i,
  input  logic          align_eop_i,
  input  logic          req_issue_i,
  output logic          credit_ok_o,
  output logic          buf_val_o,
  input  logic          buf_rdy_i,
  output logic [511:0]  buf_dat_o,
  output logic [6:0]    buf_byte_o,
  output logic          buf_eop_o,
  output logic          pkt_done_o,
  output logic [AW:0]   buf_cnt_o,
  output logic [1:0]    err_o
);

  // Entry layout: {eop, byte[6:0], dat[511:0]}
  localparam int EW = 520;

  logic [EW-1:0]          mem [DEPTH];
  logic [EW-1:0]          in_ent;

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            occ_q, occ_d;
  logic [AW:0]            rsv_q, rsv_d;
  logic                   out_vld_q, out_vld_d;
  logic [EW-1:0]          out_q, out_d;
  logic                   pkt_done_q, pkt_done_d;
  logic [1:0]             err_q, err_d;

  logic                   wr_acc;
  logic                   rd_fire;
  logic                   ram_empty;
  logic                   load_direct;
  logic                   ram_we;
  logic                   credit_ok;
  logic signed [AW+1:0]   free;
  logic [AW+1:0]          rsv_sum;

  assign in_ent = {align_eop_i, align_byte_i, align_dat_i};

  always_comb begin
    wr_acc    = align_val_i && (occ_q != (AW+1)'(DEPTH));
    rd_fire   = out_vld_q && buf_rdy_i;
    // The RAM never holds more than DEPTH-1 beats (one always sits in the
    // output register), so equal pointers can only mean empty.
    ram_empty = (wr_ptr_q == rd_ptr_q);
    // Bypass the RAM when the output register is (or is becoming) free and
    // nothing older is queued, keeping order and one-cycle latency.
    load_direct = wr_acc && (!out_vld_q || (rd_fire && ram_empty));
    ram_we      = wr_acc && !load_direct;
  end

  // Credit depends on registers only; a negative free count simply fails >= 2.
  always_comb begin
    free      = $signed((AW+2)'(DEPTH)) - $signed({1'b0, occ_q}) - $signed({1'b0, rsv_q});
    credit_ok = (free >= $signed((AW+2)'(2)));
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    occ_d      = occ_q + (AW+1)'(wr_acc) - (AW+1)'(rd_fire);
    pkt_done_d = rd_fire && out_q[EW-1];
    err_d      = err_q | {req_issue_i && !credit_ok, align_val_i && !wr_acc};

    if (ram_we) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (rd_fire && !ram_empty) begin
      // Refill from the RAM head on the same edge for 1 beat/cycle throughput.
      out_d    = mem[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else if (load_direct) begin
      out_d     = in_ent;
      out_vld_d = 1'b1;
    end else if (rd_fire) begin
      out_vld_d = 1'b0;
    end

    // A request is always reserved, even without credit; a write consumes one
    // reservation if any is outstanding. Same-cycle request+write nets +1.
    rsv_sum = {1'b0, rsv_q};
    if (req_issue_i) begin
      rsv_sum = rsv_sum + (AW+2)'(2);
    end
    if (wr_acc && (rsv_sum != '0)) begin
      rsv_sum = rsv_sum - (AW+2)'(1);
    end
    if (rsv_sum > (AW+2)'(DEPTH)) begin
      rsv_sum = (AW+2)'(DEPTH);
    end
    rsv_d = rsv_sum[AW:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      rsv_q      <= '0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      pkt_done_q <= 1'b0;
      err_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      rsv_q      <= rsv_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      pkt_done_q <= pkt_done_d;
      err_q      <= err_d;
    end
  end

  // Beat storage carries no reset; only the pointers qualify its contents.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wr_ptr_q] <= in_ent;
    end
  end

  assign credit_ok_o = credit_ok;
  assign buf_val_o   = out_vld_q;
  assign buf_dat_o   = out_q[511:0];
  assign buf_byte_o  = out_q[518:512];
  assign buf_eop_o   = out_q[EW-1];
  assign pkt_done_o  = pkt_done_q;
  assign buf_cnt_o   = occ_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_rx_buffer.sv
module tb_rx_buffer;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          align_val_i = 1'b0;
  logic [511:0]  align_dat_i = '0;
  logic [6:0]    align_byte_i = '0;
  logic          align_eop_i = 1'b0;
  logic          req_issue_i = 1'b0;
  logic          credit_ok_o;
  logic          buf_val_o;
  logic          buf_rdy_i = 1'b0;
  logic [511:0]  buf_dat_o;
  logic [6:0]    buf_byte_o;
  logic          buf_eop_o;
  logic          pkt_done_o;
  logic [AW:0]   buf_cnt_o;
  logic [1:0]    err_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a queue of {eop, byte, dat} holding every stored beat;
  // the head is what must be on the output, the size is the occupancy.
  logic [519:0] mq[$];
  int           m_rsv = 0;
  logic [1:0]   m_err = '0;
  logic         m_pkt = 1'b0;

  rx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .align_val_i(align_val_i), .align_dat_i(align_dat_i),
    .align_byte_i(align_byte_i), .align_eop_i(align_eop_i),
    .req_issue_i(req_issue_i), .credit_ok_o(credit_ok_o),
    .buf_val_o(buf_val_o), .buf_rdy_i(buf_rdy_i),
    .buf_dat_o(buf_dat_o), .buf_byte_o(buf_byte_o), .buf_eop_o(buf_eop_o),
    .pkt_done_o(pkt_done_o), .buf_cnt_o(buf_cnt_o), .err_o(err_o)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [519:0] act, input logic [519:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [511:0] rdat();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic m_credit();
    return (DEPTH - mq.size() - m_rsv) >= 2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic v, input logic [511:0] d, input logic [6:0] b, input logic e);
    align_val_i  = v;
    align_dat_i  = d;
    align_byte_i = b;
    align_eop_i  = e;
  endtask

  // Model update at each active edge (and immediately on reset assertion).
  initial forever begin : model_p
    logic fire, wacc, cred;
    int   r;
    @(posedge clk or negedge reset);
    if (!reset) begin
      mq.delete();
      m_rsv = 0;
      m_err = '0;
      m_pkt = 1'b0;
    end else begin
      cred  = m_credit();
      fire  = (mq.size() != 0) && buf_rdy_i;
      wacc  = align_val_i && (mq.size() < DEPTH);
      m_pkt = fire && mq[0][519];
      if (align_val_i && !wacc) m_err[0] = 1'b1;
      if (req_issue_i && !cred) m_err[1] = 1'b1;
      r = m_rsv + (req_issue_i ? 2 : 0);
      if (wacc && r > 0) r = r - 1;
      if (r > DEPTH) r = DEPTH;
      m_rsv = r;
      if (fire) void'(mq.pop_front());
      if (wacc) mq.push_back({align_eop_i, align_byte_i, align_dat_i});
    end
  end

  // Compare process: checks every output against the model each cycle.
  initial forever begin : cmp_p
    @(negedge clk);
    chk("buf_val", 520'(buf_val_o), 520'(mq.size() != 0));
    if (mq.size() != 0) chk("beat", {buf_eop_o, buf_byte_o, buf_dat_o}, mq[0]);
    chk("buf_cnt", 520'(buf_cnt_o), 520'(mq.size()));
    chk("pkt_done", 520'(pkt_done_o), 520'(m_pkt));
    chk("err", 520'(err_o), 520'(m_err));
    chk("credit_ok", 520'(credit_ok_o), 520'(m_credit()));
  end

  initial begin : stim_p
    int written;
    logic [511:0] d55;
    d55 = {64{8'h55}};

    // Reset and idle
    #1 reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("idle_val", 520'(buf_val_o), 520'(0));
    chk("idle_credit", 520'(credit_ok_o), 520'(1));
    chk("idle_cnt", 520'(buf_cnt_o), 520'(0));
    chk("idle_err", 520'(err_o), 520'(0));

    // Single beat, consumer ready
    buf_rdy_i = 1'b1;
    set_beat(1'b1, d55, 7'd64, 1'b1);
    step();
    set_beat(1'b0, '0, '0, 1'b0);
    chk("single_val", 520'(buf_val_o), 520'(1));
    chk("single_beat", {buf_eop_o, buf_byte_o, buf_dat_o}, {1'b1, 7'd64, d55});
    step();
    chk("single_pkt_done", 520'(pkt_done_o), 520'(1));
    chk("single_cnt", 520'(buf_cnt_o), 520'(0));

    // Simultaneous write and read keeps occupancy
    buf_rdy_i = 1'b0;
    set_beat(1'b1, rdat(), 7'd3, 1'b0);
    step();
    buf_rdy_i = 1'b1;
    set_beat(1'b1, rdat(), 7'd4, 1'b0);
    step();
    set_beat(1'b0, '0, '0, 1'b0);
    chk("wr_rd_cnt", 520'(buf_cnt_o), 520'(1));
    chk("wr_rd_byte", 520'(buf_byte_o), 520'(4));
    step();

    // Backpressure: 8 beats held, then drained in order
    buf_rdy_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      set_beat(1'b1, rdat(), 7'(i), i == 8);
      step();
    end
    set_beat(1'b0, '0, '0, 1'b0);
    step();
    chk("bp_cnt", 520'(buf_cnt_o), 520'(8));
    chk("bp_hold_byte", 520'(buf_byte_o), 520'(1));
    buf_rdy_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("bp_drain_byte", 520'(buf_byte_o), 520'(i));
      step();
    end
    chk("bp_empty", 520'(buf_cnt_o), 520'(0));
    chk("bp_pkt_done", 520'(pkt_done_o), 520'(1));

    // Credit: 15 requests leave free = 2, the 16th removes credit
    for (int i = 0; i < 15; i++) begin
      req_issue_i = 1'b1;
      step();
    end
    req_issue_i = 1'b0;
    chk("credit_after15", 520'(credit_ok_o), 520'(1));
    req_issue_i = 1'b1;
    step();
    req_issue_i = 1'b0;
    chk("credit_after16", 520'(credit_ok_o), 520'(0));
    chk("err_none_yet", 520'(err_o), 520'(0));
    req_issue_i = 1'b1;
    step();
    req_issue_i = 1'b0;
    chk("err_req_nocredit", 520'(err_o), 520'(2));
    // Writes consume reservations; credit returns only as entries free up
    set_beat(1'b1, rdat(), 7'd64, 1'b0);
    step();
    chk("credit_w1", 520'(credit_ok_o), 520'(0));
    set_beat(1'b1, rdat(), 7'd64, 1'b0);
    step();
    chk("credit_w2", 520'(credit_ok_o), 520'(0));
    set_beat(1'b1, rdat(), 7'd64, 1'b0);
    step();
    chk("credit_w3", 520'(credit_ok_o), 520'(1));
    for (int i = 0; i < 37; i++) begin
      set_beat(1'b1, rdat(), 7'($urandom_range(64, 1)), ($urandom % 4) == 0);
      step();
    end
    set_beat(1'b0, '0, '0, 1'b0);
    step();

    // Overflow: fill 32 with consumer stalled, 33rd is dropped
    buf_rdy_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_beat(1'b1, rdat(), 7'($urandom_range(64, 1)), 1'b0);
      step();
    end
    set_beat(1'b1, {512{1'b1}}, 7'd33, 1'b1);
    step();
    set_beat(1'b0, '0, '0, 1'b0);
    chk("ovf_cnt", 520'(buf_cnt_o), 520'(32));
    chk("ovf_err", 520'(err_o), 520'(3));
    buf_rdy_i = 1'b1;
    repeat (DEPTH) step();
    chk("ovf_drained", 520'(buf_cnt_o), 520'(0));
    step();

    // Asynchronous reset with 5 entries held
    buf_rdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_beat(1'b1, rdat(), 7'(i + 10), 1'b0);
      step();
    end
    set_beat(1'b0, '0, '0, 1'b0);
    chk("held5_cnt", 520'(buf_cnt_o), 520'(5));
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("arst_val", 520'(buf_val_o), 520'(0));
    chk("arst_cnt", 520'(buf_cnt_o), 520'(0));
    chk("arst_err", 520'(err_o), 520'(0));
    chk("arst_credit", 520'(credit_ok_o), 520'(1));
    chk("arst_beat", {buf_eop_o, buf_byte_o, buf_dat_o}, 520'(0));
    chk("arst_pkt", 520'(pkt_done_o), 520'(0));
    step();
    reset = 1'b1;
    step();

    // Wrap: 100 beats, consumer toggling, writer backs off near full
    written = 0;
    for (int c = 0; c < 400; c++) begin
      if (written >= 100) break;
      buf_rdy_i = (c % 2) == 1;
      if (mq.size() < DEPTH - 2) begin
        set_beat(1'b1, rdat(), 7'($urandom_range(64, 1)), ($urandom % 4) == 0);
        written++;
      end else begin
        set_beat(1'b0, '0, '0, 1'b0);
      end
      step();
    end
    set_beat(1'b0, '0, '0, 1'b0);
    buf_rdy_i = 1'b1;
    repeat (40) step();
    chk("wrap_drained", 520'(buf_cnt_o), 520'(0));

    // Fully random traffic, requests and overflow included
    for (int c = 0; c < 300; c++) begin
      set_beat(($urandom % 4) != 0, rdat(), 7'($urandom_range(64, 1)), ($urandom % 5) == 0);
      buf_rdy_i   = ($urandom % 3) != 0;
      req_issue_i = ($urandom % 8) == 0;
      step();
    end
    set_beat(1'b0, '0, '0, 1'b0);
    req_issue_i = 1'b0;
    buf_rdy_i   = 1'b1;
    repeat (40) step();
    chk("rand_drained", 520'(buf_cnt_o), 520'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
